// File: rtl/in_flight_returner_pkg.sv
// Constants and helpers shared by the returner, its arbiter and the issue-side tracker.
// log2() gives the number of bits needed to hold a value, never less than one.
package in_flight_returner_pkg;

  function automatic int log2(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) <= value) bits++;
    return bits;
  endfunction

  localparam int N_COLORS    = 4;
  localparam int LOG2_COLORS = log2(N_COLORS - 1);
  localparam int N_DEPTH     = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant; the pointer only
// moves when the grant is actually taken (advance), so a stalled consumer keeps priority fixed.
module rr_arbiter
  import in_flight_returner_pkg::*;
#(
  parameter int N = N_COLORS,
  localparam int IW = log2(N - 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0] last_grant;
  logic [IW-1:0] cand;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant       = '0;
    cand        = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(last_grant) + i) % N);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

  // Reset to N-1 so colour 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= IW'(N - 1);
    end else if (advance && grant_valid) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/in_flight_returner.sv
// Buffers tagged responses in per-colour FIFOs carved from one shared array and drains
// them round-robin through a single output register; pop retires the entry in the tracker.
module in_flight_returner
  import in_flight_returner_pkg::*;
#(
  parameter int COLORS = N_COLORS,
  parameter int DEPTH  = N_DEPTH,
  parameter int WIDTH  = 64,
  localparam int CW    = log2(COLORS - 1),
  localparam int PW    = log2(DEPTH - 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              resp_valid,
  input  logic [CW-1:0]     resp_tag,
  input  logic [WIDTH-1:0]  resp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     out_tag,
  output logic [WIDTH-1:0]  out_data,
  output logic              pop,
  output logic [CW-1:0]     pop_tag,
  output logic [COLORS-1:0] empty,
  output logic              overflow
);

  localparam int CNTW = PW + 1;
  localparam int AW   = CW + PW;

  logic [WIDTH-1:0] mem [COLORS*DEPTH];

  logic [PW-1:0]   wr_ptr [COLORS];
  logic [PW-1:0]   rd_ptr [COLORS];
  logic [CNTW-1:0] count  [COLORS];

  logic              load_en;
  logic              wr_ok;
  logic              deq;
  logic [COLORS-1:0] wr_hit;
  logic [COLORS-1:0] rd_hit;
  logic [COLORS-1:0] grant;
  logic [CW-1:0]     grant_idx;
  logic              grant_valid;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     rd_addr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign load_en = !out_valid || out_ready;
  assign deq     = load_en && grant_valid;

  // Uses the registered count, so a slot freed by a same-cycle read is not reusable yet.
  assign wr_ok   = resp_valid && (count[resp_tag] != CNTW'(DEPTH));

  assign wr_addr = {resp_tag, wr_ptr[resp_tag]};
  assign rd_addr = {grant_idx, rd_ptr[grant_idx]};

  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    empty  = '0;
    for (int c = 0; c < COLORS; c++) begin
      wr_hit[c] = wr_ok && (resp_tag == CW'(c));
      rd_hit[c] = deq && grant[c];
      empty[c]  = (count[c] == '0);
    end
  end

  rr_arbiter #(
    .N (COLORS)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (~empty),
    .advance     (load_en),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= resp_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < COLORS; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < COLORS; c++) begin
        if (wr_hit[c]) wr_ptr[c] <= next_ptr(wr_ptr[c]);
        if (rd_hit[c]) rd_ptr[c] <= next_ptr(rd_ptr[c]);
        if (wr_hit[c] && !rd_hit[c]) begin
          count[c] <= count[c] + CNTW'(1);
        end else if (rd_hit[c] && !wr_hit[c]) begin
          count[c] <= count[c] - CNTW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (resp_valid && !wr_ok) overflow <= 1'b1;
      if (load_en) begin
        out_valid <= grant_valid;
        if (grant_valid) begin
          out_tag  <= grant_idx;
          out_data <= mem[rd_addr];
        end
      end
    end
  end

  assign pop     = out_valid && out_ready;
  assign pop_tag = out_tag;

endmodule

// File: doc/in_flight_returner.md
Name: in_flight_returner

Overview:
- Response-side counterpart to the in-flight request tracker.
- Accepts tagged responses from memory or a decoder pipe and buffers them in per-colour FIFOs inside one shared storage array.
- Drains the FIFOs round-robin to a single valid/ready consumer port.
- Emits the pop/pop_tag pulse that retires each entry in the tracker, in the same cycle the consumer accepts it.

Parameters:
- COLORS, 4, number of tags/colours; LOG2_COLORS = log2(COLORS-1) from common.vh.
- DEPTH, 32, entries per colour; equals the tracker's MIN_DEPTH. LOG2_DEPTH = log2(DEPTH-1).
- WIDTH, 64, response data width.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- resp_valid  in  1  response present this cycle; there is no backpressure.
- resp_tag  in  LOG2_COLORS  colour of the response.
- resp_data  in  WIDTH  response payload.
- out_valid  out  1  output register holds an entry.
- out_ready  in  1  consumer accepts.
- out_tag  out  LOG2_COLORS  colour of the output entry.
- out_data  out  WIDTH  payload of the output entry.
- pop  out  1  retire pulse to the tracker; equals out_valid && out_ready.
- pop_tag  out  LOG2_COLORS  equals out_tag.
- empty  out  COLORS  bit c high when FIFO c count == 0.
- overflow  out  1  sticky error flag.

Behaviour:
- Storage: array of COLORS*DEPTH words x WIDTH, addressed {colour, ptr}. Read is combinational (distributed RAM). The array is not reset.
- Per-colour state: wr_ptr and rd_ptr (LOG2_DEPTH bits, wrap modulo DEPTH) and count (LOG2_DEPTH+1 bits, range 0..DEPTH).
- Write: on resp_valid, if count[resp_tag] < DEPTH:
  - store at {resp_tag, wr_ptr[resp_tag]};
  - increment wr_ptr;
  - count +1.
- Overflow: if count[resp_tag] == DEPTH, the response is dropped, no pointer or count changes, and overflow is set to 1 until rst.
  - Sim-only: $display an error and $finish, guarded by synthesis off/on.
- Output stage: a single register (out_valid, out_tag, out_data).
  - load_en = !out_valid || out_ready.
  - When load_en, the arbiter picks a colour. If one is found, the register loads {1, colour, mem[{colour, rd_ptr}]}, rd_ptr for that colour increments, and its count -1. If none, out_valid <= 0.
  - Full throughput: one entry per cycle under continuous out_ready.
- Arbiter:
  - Eligible colour = count > 0, using registered counts. A response written at edge k is eligible from cycle k+1, so out_valid rises after edge k+1 at the earliest (2-edge latency into an idle block).
  - Round-robin: search starts at last_grant+1 modulo COLORS. last_grant updates only on a successful load.
- Simultaneous write and read of the same colour in one cycle: count unchanged, both pointers advance.
  - When count == DEPTH, the read's freed slot is not visible to a same-cycle write. The write is treated as overflow.
- Hold rule: while out_valid && !out_ready, out_tag and out_data stay stable and no dequeue occurs.
- pop and pop_tag are combinational from the output register and out_ready. Exactly one pop per delivered entry.
- Wrap-around: pointers wrap DEPTH-1 -> 0 with no gap. FIFO order per colour is strict.
- Reset (any time, including mid-transfer):
  - out_valid = 0, pop = 0, overflow = 0;
  - all counts, pointers = 0;
  - empty = all ones;
  - last_grant = COLORS-1, so colour 0 has first priority.
  - In-flight data is discarded.

Decomposition:
- Shared package/header (common.vh): log2 function.
- Shared package/header (colour constants): COLORS, LOG2_COLORS, shared with the tracker.
- Sub-module rr_arbiter (COLORS requests, one-hot/encoded grant, rotate on enable) is natural. It is reusable by the issue-side scheduler.
- Per-colour FIFO control stays inline because the storage is shared.

Test Plan:
- Single response: resp tag 2, data 0xAB at edge 0, out_ready = 1 -> out_valid after edge 1 with tag 2, data 0xAB; pop = 1 with pop_tag 2 for exactly one cycle; empty = 4'b1111 afterwards.
- Round-robin: one entry each in colours 0..3 preloaded with out_ready = 0, then out_ready = 1 -> tags delivered 0, 1, 2, 3, then 0 again after a refill of colour 0 and colour 1.
- Backpressure: out_ready low for 5 cycles with out_valid high -> out_tag and out_data stable, pop = 0, counts unchanged.
- Full and overflow: 32 writes to colour 1 then a 33rd -> 33rd dropped, overflow = 1 (sticky); draining yields exactly 32 entries in write order.
- Wrap and simultaneous events: 100 entries streamed through colour 3 with a write and read in the same cycle -> in-order data, count never exceeds 2, pointers wrap cleanly.
- Reset mid-operation: assert rst with 3 entries queued and out_valid = 1 -> out_valid = 0 and empty = all ones immediately, overflow cleared, first post-reset write delivered normally.
